// File: rtl/tv_drv_pkg.sv
// Shared types and constants for the bit-serial test-vector driver and its
// response-compaction MISR.
package tv_drv_pkg;

    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    // One MISR step: the feedback bit folds the response into the top bit
    // before the shift.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic             bit_in
    );
        logic fb;
        fb = sig[SIG_W-1] ^ bit_in;
        return {sig[SIG_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
    endfunction

endpackage

// File: rtl/tv_serial_driver_if.sv
// Vector handshake between a stimulus source (master) and the serial driver
// (slave).
interface tv_serial_driver_if #(
    parameter int VEC_W = 8
);
    logic [VEC_W-1:0] vec_data;
    logic             vec_valid;
    logic             vec_ready;

    modport master (
        output vec_data,
        output vec_valid,
        input  vec_ready
    );

    modport slave (
        input  vec_data,
        input  vec_valid,
        output vec_ready
    );
endinterface

// File: rtl/tv_misr16.sv
// 16-bit MISR signature register. Clear takes priority over capture so a
// clear always yields an all-zero signature on the next cycle.
module tv_misr16
    import tv_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] sig_q;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_step(sig_q, bit_in);
        end
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/tv_serial_driver.sv
// Bit-serial test-vector transmitter: shifts accepted vectors out LSB-first
// with a frame strobe and compacts the response into a MISR signature.
// Define TV_DRV_PARITY_EN to append an even-parity bit to every frame.
module tv_serial_driver
    import tv_drv_pkg::*;
#(
    parameter int VEC_W = 8,
    parameter int GAP   = 2
) (
    input  logic                     I1470_clk,
    input  logic                     I1477_rst,
    tv_serial_driver_if.slave        vec_if,
    output logic                     ser_out,
    output logic                     ser_frame,
    input  logic                     resp_in,
    input  logic                     sig_clr,
    output logic [SIG_W-1:0]         sig_out,
    output logic                     done
);

`ifdef TV_DRV_PARITY_EN
    localparam int FRAME_W = VEC_W + 1;
`else
    localparam int FRAME_W = VEC_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    logic [FRAME_W-1:0] frame_word;

`ifdef TV_DRV_PARITY_EN
    assign frame_word = {^vec_if.vec_data, vec_if.vec_data};
`else
    assign frame_word = vec_if.vec_data;
`endif

    state_e             state_d, state_q;
    logic [FRAME_W-2:0] shift_d, shift_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [GAP_W-1:0]   gap_d, gap_q;
    logic               ser_out_d, ser_out_q;
    logic               ser_frame_d, ser_frame_q;
    logic               done_d, done_q;

    // Bit 0 is registered straight from the handshake so it appears on the
    // cycle after acceptance; shift_q holds only the bits still to be sent.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        ser_out_d   = 1'b0;
        ser_frame_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (vec_if.vec_valid) begin
                    state_d     = S_SHIFT;
                    ser_out_d   = frame_word[0];
                    ser_frame_d = 1'b1;
                    shift_d     = frame_word[FRAME_W-1:1];
                    cnt_d       = '0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    ser_out_d   = shift_q[0];
                    ser_frame_d = 1'b1;
                    shift_d     = shift_q >> 1;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ser_out_q   <= ser_out_d;
            ser_frame_q <= ser_frame_d;
            done_q      <= done_d;
        end
    end

    // Ready is gated by reset combinationally so no vector can be taken while
    // the driver is being reset.
    assign vec_if.vec_ready = (state_q == S_IDLE) && !I1477_rst;

    assign ser_out   = ser_out_q;
    assign ser_frame = ser_frame_q;
    assign done      = done_q;

    tv_misr16 u_misr (
        .clk    (I1470_clk),
        .rst    (I1477_rst),
        .clr    (sig_clr),
        .en     (ser_frame_q),
        .bit_in (resp_in),
        .sig    (sig_out)
    );

endmodule

// File: tb/tb_tv_serial_driver.sv
// Self-checking bench for tv_serial_driver: directed frames from the test plan
// plus randomized frames against a cycle-level reference model.
module tb_tv_serial_driver;

    localparam int VEC_W = 8;
    localparam int GAP   = 2;
`ifdef TV_DRV_PARITY_EN
    localparam int FRAME_W = VEC_W + 1;
    localparam logic [15:0] SIG_A5_BIT0 = 16'h3331;
`else
    localparam int FRAME_W = VEC_W;
    localparam logic [15:0] SIG_A5_BIT0 = 16'h9188;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ser_out;
    logic        ser_frame;
    logic        resp_in;
    logic        sig_clr;
    logic [15:0] sig_out;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_sig;

    tv_serial_driver_if #(.VEC_W(VEC_W)) vec_if ();

    tv_serial_driver #(
        .VEC_W (VEC_W),
        .GAP   (GAP)
    ) dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .vec_if    (vec_if),
        .ser_out   (ser_out),
        .ser_frame (ser_frame),
        .resp_in   (resp_in),
        .sig_clr   (sig_clr),
        .sig_out   (sig_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Frame bit i: data LSB-first, then the even-parity bit when enabled.
    function automatic logic exp_bit(input logic [VEC_W-1:0] v, input int i);
        if (i < VEC_W) return v[i];
        return ^v;
    endfunction

    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic b);
        int unsigned acc;
        acc = {16'h0, s} << 1;
        if (s[15] ^ b) acc = acc ^ 32'h0000_1021;
        return acc[15:0];
    endfunction

    // Offers vec, walks the whole frame and gap checking every cycle.
    // clr_at: frame bit on which sig_clr is raised (-1 none).
    // abort_at: frame bit on which reset is asserted (-1 none).
    task automatic send_frame(input logic [VEC_W-1:0] vec, input logic [FRAME_W-1:0] resp,
                              input int clr_at, input int abort_at);
        int waited = 0;
        vec_if.vec_data  = vec;
        vec_if.vec_valid = 1'b1;
        while (vec_if.vec_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (vec_if.vec_ready !== 1'b1) begin
            check("ready_timeout", 32'(vec_if.vec_ready), 32'd1);
            vec_if.vec_valid = 1'b0;
            return;
        end
        @(negedge clk);
        for (int i = 0; i < FRAME_W; i++) begin
            check("frame_hi", 32'(ser_frame), 32'd1);
            check("ser_bit", 32'(ser_out), 32'(exp_bit(vec, i)));
            check("busy", 32'(vec_if.vec_ready), 32'd0);
            vec_if.vec_valid = 1'($urandom_range(0, 1));
            vec_if.vec_data  = VEC_W'($urandom);
            if (i == abort_at) begin
                rst     = 1'b1;
                resp_in = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("abort_frame", 32'(ser_frame), 32'd0);
                check("abort_out", 32'(ser_out), 32'd0);
                check("abort_sig", 32'(sig_out), 32'd0);
                check("abort_ready", 32'(vec_if.vec_ready), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                rst              = 1'b0;
                resp_in          = 1'b0;
                vec_if.vec_valid = 1'b0;
                model_sig        = '0;
                #1;
                check("release_ready", 32'(vec_if.vec_ready), 32'd1);
                check("release_done", 32'(done), 32'd0);
                return;
            end
            resp_in   = resp[i];
            sig_clr   = (i == clr_at);
            model_sig = sig_clr ? 16'h0000 : ref_misr(model_sig, resp[i]);
            @(negedge clk);
        end
        resp_in = 1'b0;
        sig_clr = 1'b0;
        check("done", 32'(done), 32'd1);
        check("sig", 32'(sig_out), 32'(model_sig));
        check("frame_lo", 32'(ser_frame), 32'd0);
        for (int g = 0; g < GAP; g++) begin
            check("gap_ready", 32'(vec_if.vec_ready), 32'd0);
            check("gap_out", 32'(ser_out), 32'd0);
            check("gap_frame", 32'(ser_frame), 32'd0);
            if (g > 0) check("gap_done", 32'(done), 32'd0);
            vec_if.vec_valid = 1'($urandom_range(0, 1));
            vec_if.vec_data  = VEC_W'($urandom);
            @(negedge clk);
        end
        check("ready_back", 32'(vec_if.vec_ready), 32'd1);
        check("done_pulse", 32'(done), 32'(GAP == 0));
        vec_if.vec_valid = 1'b0;
    endtask

    task automatic clear_sig();
        sig_clr = 1'b1;
        @(negedge clk);
        sig_clr   = 1'b0;
        model_sig = '0;
        check("sig_clr", 32'(sig_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int clr_at;
        rst              = 1'b1;
        resp_in          = 1'b0;
        sig_clr          = 1'b0;
        vec_if.vec_valid = 1'b0;
        vec_if.vec_data  = '0;
        model_sig        = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(vec_if.vec_ready), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_frame", 32'(ser_frame), 32'd0);
        check("rst_sig", 32'(sig_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // 0xA5 with a single response 1 on bit 0, from a zero signature.
        send_frame(8'hA5, FRAME_W'(1), -1, -1);
        check("sig_a5_bit0", 32'(sig_out), 32'(SIG_A5_BIT0));

        clear_sig();
        send_frame(8'hA5, '0, -1, -1);
        check("sig_a5_zero", 32'(sig_out), 32'd0);

        // Parity-bit case and minimum-spacing back-to-back frames.
        send_frame(8'h07, FRAME_W'($urandom), -1, -1);
        send_frame(8'h01, FRAME_W'($urandom), -1, -1);
        send_frame(8'hFF, FRAME_W'($urandom), -1, -1);

        // Reset while bit 3 is on the line, then a normal frame.
        send_frame(VEC_W'($urandom), FRAME_W'($urandom), -1, 3);
        send_frame(8'h3C, FRAME_W'($urandom), -1, -1);

        // Clear coinciding with the bit-7 capture, response 1 throughout.
        send_frame(VEC_W'($urandom), '1, 7, -1);

        for (int n = 0; n < 16; n++) begin
            clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME_W - 1)) : -1;
            send_frame(VEC_W'($urandom), FRAME_W'($urandom), clr_at, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
